// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic datapath blocks.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand and result handshakes of the bit-serial adder/subtractor.
interface serial_add_sub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/serial_fa_bit.sv
// Combinational one-bit full adder cell.
module serial_fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and one carry flop, LSB first.
// Subtraction is A + ~B + 1, so cout=1 means no borrow.
module serial_add_sub
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   serial_add_sub_if.slave bus
);
   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] shr_q, shr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             fa_s, fa_c;

   serial_fa_bit u_fa (
      .a    (sha_q[0]),
      .b    (shb_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         shr_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         shr_q   <= shr_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      shr_d   = shr_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sha_d   = bus.a;
               shb_d   = (bus.sub == MODE_ADD) ? bus.b : ~bus.b;
               carry_d = (bus.sub == MODE_SUB);
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sha_d   = {1'b0, sha_q[WIDTH-1:1]};
            shb_d   = {1'b0, shb_q[WIDTH-1:1]};
            shr_d   = {fa_s, shr_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // carry_q is the carry into the MSB on this final step
               cout_d  = fa_c;
               ovf_d   = carry_q ^ fa_c;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = shr_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=8 (directed) and WIDTH=4 (exhaustive).
module tb_serial_add_sub;

   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q8[$];
   exp_t q4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_sub_if #(.WIDTH(8)) bus8 ();
   serial_add_sub_if #(.WIDTH(4)) bus4 ();

   serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_add_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: A + (sub ? ~B + 1 : B) computed with a wide integer add.
   function automatic exp_t model(input int unsigned w, input logic [63:0] a,
                                  input logic [63:0] b, input logic sub);
      logic [64:0] mask, aa, bb, full;
      exp_t        e;
      mask   = (65'd1 << w) - 65'd1;
      aa     = {1'b0, a} & mask;
      bb     = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
      full   = aa + bb + 65'(sub);
      e.sum  = full[63:0] & mask[63:0];
      e.cout = full[w];
      e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus8.out_valid && bus8.out_ready) begin
         if (q8.size() == 0) begin
            check("w8 spurious result", 64'(bus8.out_valid), 64'd0);
         end else begin
            exp_t e;
            e = q8.pop_front();
            check("w8 sum", 64'(bus8.sum), e.sum);
            check("w8 cout", 64'(bus8.cout), 64'(e.cout));
            check("w8 ovf", 64'(bus8.ovf), 64'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus4.out_valid && bus4.out_ready) begin
         if (q4.size() == 0) begin
            check("w4 spurious result", 64'(bus4.out_valid), 64'd0);
         end else begin
            exp_t e;
            e = q4.pop_front();
            check("w4 sum", 64'(bus4.sum), e.sum);
            check("w4 cout", 64'(bus4.cout), 64'(e.cout));
            check("w4 ovf", 64'(bus4.ovf), 64'(e.ovf));
         end
      end
   end

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit push, output int acc);
      bus8.a        = a;
      bus8.b        = b;
      bus8.sub      = s;
      bus8.in_valid = 1'b1;
      if (push) q8.push_back(model(8, 64'(a), 64'(b), s));
      acc = -1;
      for (int k = 0; k < 100; k++) begin
         if (bus8.in_ready) begin
            @(posedge clk); #1;
            acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      bus8.in_valid = 1'b0;
      if (acc < 0) check("w8 accept timeout", 64'(bus8.in_ready), 64'd1);
   endtask

   task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s);
      bit ok;
      bus4.a        = a;
      bus4.b        = b;
      bus4.sub      = s;
      bus4.in_valid = 1'b1;
      q4.push_back(model(4, 64'(a), 64'(b), s));
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (bus4.in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      bus4.in_valid = 1'b0;
      if (!ok) check("w4 accept timeout", 64'(bus4.in_ready), 64'd1);
   endtask

   // Cycles after acceptance until out_valid is seen; optionally scrambles operand inputs.
   task automatic wait_out8(input int max, input bit scramble, output int lat);
      lat = 0;
      for (int k = 1; k <= max; k++) begin
         if (scramble) begin
            bus8.a   = 8'($urandom);
            bus8.b   = 8'($urandom);
            bus8.sub = 1'($urandom);
         end
         @(posedge clk); #1;
         if (bus8.out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int   acc, prev, lat;
      exp_t e;
      logic [7:0] va[5] = '{8'h3C, 8'hFF, 8'h7F, 8'h10, 8'h80};
      logic [7:0] vb[5] = '{8'h15, 8'h01, 8'h01, 8'h20, 8'h01};
      logic       vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0; bus8.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 64'(bus8.in_ready), 64'd1);
      check("reset out_valid", 64'(bus8.out_valid), 64'd0);
      check("reset busy", 64'(bus8.busy), 64'd0);
      check("reset sum", 64'(bus8.sum), 64'd0);
      check("reset cout", 64'(bus8.cout), 64'd0);
      check("reset ovf", 64'(bus8.ovf), 64'd0);
      rst = 1'b0;

      // Latency and unbounded back-pressure on the first vector
      send8(va[0], vb[0], vs[0], 1'b1, acc);
      check("w8 busy in run", 64'(bus8.busy), 64'd1);
      wait_out8(20, 1'b0, lat);
      check("w8 latency", 64'(lat), 64'd8);
      e = model(8, 64'(va[0]), 64'(vb[0]), vs[0]);
      check("w8 first sum", 64'(bus8.sum), 64'h51);
      repeat (5) begin
         @(posedge clk); #1;
         check("hold out_valid", 64'(bus8.out_valid), 64'd1);
         check("hold in_ready", 64'(bus8.in_ready), 64'd0);
         check("hold sum", 64'(bus8.sum), e.sum);
         check("hold cout", 64'(bus8.cout), 64'(e.cout));
         check("hold ovf", 64'(bus8.ovf), 64'(e.ovf));
      end
      bus8.out_ready = 1'b1;

      // Remaining directed vectors, with operands scrambled while running
      for (int i = 1; i < 5; i++) begin
         send8(va[i], vb[i], vs[i], 1'b1, acc);
         wait_out8(20, 1'b1, lat);
         check("w8 latency scrambled", 64'(lat), 64'd8);
      end

      // Back-to-back: one acceptance every WIDTH+2 cycles
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, acc);
         if (i > 0) check("w8 b2b interval", 64'(acc - prev), 64'd10);
         prev = acc;
      end

      // Asynchronous reset while bit 3 is pending
      send8(8'h55, 8'h0F, 1'b0, 1'b0, acc);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst run in_ready", 64'(bus8.in_ready), 64'd1);
      check("rst run out_valid", 64'(bus8.out_valid), 64'd0);
      check("rst run busy", 64'(bus8.busy), 64'd0);
      check("rst run sum", 64'(bus8.sum), 64'd0);
      check("rst run cout", 64'(bus8.cout), 64'd0);
      check("rst run ovf", 64'(bus8.ovf), 64'd0);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send8(8'h01, 8'h01, 1'b0, 1'b1, acc);
      wait_out8(20, 1'b0, lat);
      check("w8 after reset latency", 64'(lat), 64'd8);
      check("w8 after reset sum", 64'(bus8.sum), 64'h02);

      // Exhaustive at WIDTH=4
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               send4(4'(a), 4'(b), 1'(s));

      for (int k = 0; k < 100 && (q4.size() != 0 || q8.size() != 0); k++) @(posedge clk);
      #1;
      check("w8 scoreboard drained", 64'(q8.size()), 64'd0);
      check("w4 scoreboard drained", 64'(q4.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
